// File: rtl/swc_rtu_rsp_buffer.sv
// Demultiplexes the shared RTU response channel into per-port FIFOs and presents each
// FIFO head to swcore as registered show-ahead outputs on a valid/ack handshake.
module swc_rtu_rsp_buffer #(
  parameter int unsigned g_num_ports      = 7,
  parameter int unsigned g_prio_width     = 3,
  parameter int unsigned g_fifo_depth     = 4,
  parameter int unsigned g_port_idx_width = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 rtu_valid_i,
  input  logic [g_port_idx_width-1:0]          rtu_port_i,
  input  logic [g_num_ports-1:0]               rtu_mask_i,
  input  logic                                 rtu_drop_i,
  input  logic [g_prio_width-1:0]              rtu_prio_i,
  output logic                                 rtu_ready_o,
  input  logic [g_num_ports-1:0]               rtu_flush_i,
  output logic [g_num_ports-1:0]               rtu_rsp_valid_o,
  input  logic [g_num_ports-1:0]               rtu_rsp_ack_i,
  output logic [g_num_ports*g_num_ports-1:0]   rtu_dst_port_mask_o,
  output logic [g_num_ports-1:0]               rtu_drop_o,
  output logic [g_num_ports*g_prio_width-1:0]  rtu_prio_o,
  output logic                                 err_bad_port_o
);

  localparam int unsigned N  = g_num_ports;
  localparam int unsigned P  = g_prio_width;
  localparam int unsigned PW = g_port_idx_width;
  localparam int unsigned AW = $clog2(g_fifo_depth);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = N + 1 + P;

  logic [DW-1:0] r_mem  [N][g_fifo_depth];
  logic [AW-1:0] r_rp   [N];
  logic [AW-1:0] r_wp   [N];
  logic [CW-1:0] r_cnt  [N];
  logic [DW-1:0] r_head [N];
  logic [N-1:0]  r_vld;
  logic          r_err;

  logic [DW-1:0] w_din;
  logic          w_in_range;
  logic          w_ready;
  logic [N-1:0]  w_full;
  logic [N-1:0]  w_push;
  logic [N-1:0]  w_pop;
  logic [AW-1:0] w_nxt_rp   [N];
  logic [AW-1:0] w_nxt_wp   [N];
  logic [CW-1:0] w_nxt_cnt  [N];
  logic [DW-1:0] w_nxt_head [N];

  assign w_din      = {rtu_mask_i, rtu_drop_i, rtu_prio_i};
  assign w_in_range = {1'b0, rtu_port_i} < (PW+1)'(N);

  // Ready reflects only the addressed FIFO; out-of-range responses are always sunk.
  always_comb begin
    w_ready = 1'b1;
    for (int p = 0; p < int'(N); p++) begin
      if (rtu_port_i == PW'(p)) w_ready = !w_full[p];
    end
  end

  assign rtu_ready_o = w_ready;

  // Next FIFO state and next show-ahead head, including a head written this cycle.
  always_comb begin
    for (int p = 0; p < int'(N); p++) begin
      w_full[p]     = (r_cnt[p] == CW'(g_fifo_depth));
      w_push[p]     = rtu_valid_i && w_in_range && (rtu_port_i == PW'(p)) && !w_full[p];
      w_pop[p]      = rtu_rsp_ack_i[p] && r_vld[p];
      w_nxt_rp[p]   = r_rp[p] + AW'(w_pop[p]);
      w_nxt_wp[p]   = r_wp[p] + AW'(w_push[p]);
      w_nxt_cnt[p]  = r_cnt[p] + CW'(w_push[p]) - CW'(w_pop[p]);
      w_nxt_head[p] = '0;
      if (rtu_flush_i[p]) begin
        w_nxt_rp[p]  = '0;
        w_nxt_wp[p]  = '0;
        w_nxt_cnt[p] = '0;
      end else if (w_nxt_cnt[p] != '0) begin
        if (w_push[p] && (w_nxt_rp[p] == r_wp[p])) w_nxt_head[p] = w_din;
        else                                       w_nxt_head[p] = r_mem[p][w_nxt_rp[p]];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < int'(N); p++) begin
      if (w_push[p] && !rtu_flush_i[p]) r_mem[p][r_wp[p]] <= w_din;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int p = 0; p < int'(N); p++) begin
        r_rp[p]   <= '0;
        r_wp[p]   <= '0;
        r_cnt[p]  <= '0;
        r_head[p] <= '0;
      end
      r_vld <= '0;
      r_err <= 1'b0;
    end else begin
      for (int p = 0; p < int'(N); p++) begin
        r_rp[p]   <= w_nxt_rp[p];
        r_wp[p]   <= w_nxt_wp[p];
        r_cnt[p]  <= w_nxt_cnt[p];
        r_head[p] <= w_nxt_head[p];
        r_vld[p]  <= (w_nxt_cnt[p] != '0);
      end
      r_err <= rtu_valid_i && !w_in_range;
    end
  end

  for (genvar p = 0; p < int'(N); p++) begin : g_out
    assign rtu_dst_port_mask_o[p*N +: N] = r_head[p][DW-1 -: N];
    assign rtu_drop_o[p]                 = r_head[p][P];
    assign rtu_prio_o[p*P +: P]          = r_head[p][P-1:0];
  end

  assign rtu_rsp_valid_o = r_vld;
  assign err_bad_port_o  = r_err;

endmodule

// File: tb/tb_swc_rtu_rsp_buffer.sv
// Bench for swc_rtu_rsp_buffer: directed scenarios plus random traffic, checked against
// a per-port queue model of the response buffer.
module tb_swc_rtu_rsp_buffer;

  localparam int unsigned N = 7;
  localparam int unsigned P = 3;
  localparam int unsigned D = 4;

  typedef struct packed {
    logic [N-1:0] mask;
    logic         drop;
    logic [P-1:0] prio;
  } ent_t;

  logic           clk_i = 1'b0;
  logic           rst_n_i;
  logic           rtu_valid_i;
  logic [2:0]     rtu_port_i;
  logic [N-1:0]   rtu_mask_i;
  logic           rtu_drop_i;
  logic [P-1:0]   rtu_prio_i;
  logic           rtu_ready_o;
  logic [N-1:0]   rtu_flush_i;
  logic [N-1:0]   rtu_rsp_valid_o;
  logic [N-1:0]   rtu_rsp_ack_i;
  logic [N*N-1:0] rtu_dst_port_mask_o;
  logic [N-1:0]   rtu_drop_o;
  logic [N*P-1:0] rtu_prio_o;
  logic           err_bad_port_o;

  swc_rtu_rsp_buffer dut (
    .clk_i               (clk_i),
    .rst_n_i             (rst_n_i),
    .rtu_valid_i         (rtu_valid_i),
    .rtu_port_i          (rtu_port_i),
    .rtu_mask_i          (rtu_mask_i),
    .rtu_drop_i          (rtu_drop_i),
    .rtu_prio_i          (rtu_prio_i),
    .rtu_ready_o         (rtu_ready_o),
    .rtu_flush_i         (rtu_flush_i),
    .rtu_rsp_valid_o     (rtu_rsp_valid_o),
    .rtu_rsp_ack_i       (rtu_rsp_ack_i),
    .rtu_dst_port_mask_o (rtu_dst_port_mask_o),
    .rtu_drop_o          (rtu_drop_o),
    .rtu_prio_o          (rtu_prio_o),
    .err_bad_port_o      (err_bad_port_o)
  );

  always #5 clk_i = ~clk_i;

  ent_t q [8][$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input logic exp_err);
    logic [N-1:0]   ev;
    logic [N*N-1:0] em;
    logic [N-1:0]   ed;
    logic [N*P-1:0] ep;
    ev = '0; em = '0; ed = '0; ep = '0;
    for (int p = 0; p < int'(N); p++) begin
      if (q[p].size() > 0) begin
        ev[p]       = 1'b1;
        em[p*N +: N] = q[p][0].mask;
        ed[p]       = q[p][0].drop;
        ep[p*P +: P] = q[p][0].prio;
      end
    end
    chk("valid", 64'(rtu_rsp_valid_o), 64'(ev));
    chk("mask",  64'(rtu_dst_port_mask_o), 64'(em));
    chk("drop",  64'(rtu_drop_o), 64'(ed));
    chk("prio",  64'(rtu_prio_o), 64'(ep));
    chk("err",   64'(err_bad_port_o), 64'(exp_err));
  endtask

  // One clock: check ready against the model, clock, update the model, check outputs.
  task automatic cycle();
    logic   exp_ready, acc, badp;
    logic [N-1:0] pop;
    ent_t   e;
    #1;
    exp_ready = (rtu_port_i >= 3'(N)) ? 1'b1 : (q[rtu_port_i].size() < D);
    chk("ready", 64'(rtu_ready_o), 64'(exp_ready));
    acc  = rtu_valid_i && exp_ready && (rtu_port_i < 3'(N));
    badp = rtu_valid_i && (rtu_port_i >= 3'(N));
    e    = '{mask: rtu_mask_i, drop: rtu_drop_i, prio: rtu_prio_i};
    for (int p = 0; p < int'(N); p++) pop[p] = rtu_rsp_ack_i[p] && (q[p].size() > 0);
    @(posedge clk_i);
    for (int p = 0; p < int'(N); p++) if (pop[p]) void'(q[p].pop_front());
    if (acc) q[rtu_port_i].push_back(e);
    for (int p = 0; p < int'(N); p++) if (rtu_flush_i[p]) q[p].delete();
    #1;
    chk_outputs(badp);
  endtask

  task automatic idle();
    rtu_valid_i = 1'b0; rtu_port_i = '0; rtu_mask_i = '0; rtu_drop_i = 1'b0;
    rtu_prio_i = '0; rtu_flush_i = '0; rtu_rsp_ack_i = '0;
  endtask

  task automatic push(input int port, input logic [N-1:0] m, input logic d, input logic [P-1:0] pr);
    rtu_valid_i = 1'b1; rtu_port_i = 3'(port); rtu_mask_i = m; rtu_drop_i = d; rtu_prio_i = pr;
  endtask

  initial begin
    idle();
    rst_n_i = 1'b0;
    #3;
    chk("rst_valid", 64'(rtu_rsp_valid_o), 64'd0);
    chk("rst_ready", 64'(rtu_ready_o), 64'd1);
    @(negedge clk_i); @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // T1: three entries on port 2, then async reset mid-cycle
    for (int i = 0; i < 3; i++) begin push(2, 7'(i + 1), 1'b0, 3'(i)); cycle(); end
    idle();
    #2 rst_n_i = 1'b0;
    #1;
    chk("t1_async_valid", 64'(rtu_rsp_valid_o), 64'd0);
    chk("t1_async_mask",  64'(rtu_dst_port_mask_o), 64'd0);
    chk("t1_async_prio",  64'(rtu_prio_o), 64'd0);
    for (int p = 0; p < 8; p++) q[p].delete();
    @(negedge clk_i); @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk_outputs(1'b0);
    chk("t1_ready", 64'(rtu_ready_o), 64'd1);

    // T2: latency and single ack
    push(0, 7'b0000010, 1'b0, 3'd5); cycle();
    chk("t2_valid0", 64'(rtu_rsp_valid_o[0]), 64'd1);
    chk("t2_mask0",  64'(rtu_dst_port_mask_o[6:0]), 64'h02);
    chk("t2_prio0",  64'(rtu_prio_o[2:0]), 64'd5);
    idle(); rtu_rsp_ack_i[0] = 1'b1; cycle();
    chk("t2_gone", 64'(rtu_rsp_valid_o[0]), 64'd0);
    idle();

    // T3: fill port 3; ready low for 3, high for 4; ack + refused push
    for (int i = 0; i < 4; i++) begin push(3, 7'h7f, 1'b1, 3'(i)); cycle(); end
    idle(); rtu_port_i = 3'd3; #1 chk("t3_ready3", 64'(rtu_ready_o), 64'd0);
    rtu_port_i = 3'd4; cycle();
    push(3, 7'h11, 1'b0, 3'd7); rtu_rsp_ack_i[3] = 1'b1; cycle();
    chk("t3_count3", 64'(q[3].size()), 64'd3);
    idle(); rtu_rsp_ack_i[3] = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    idle();

    // T4: ten pushes to port 1 with acks, wrapping the pointers
    for (int i = 0; i < 10; i++) begin
      push(1, 7'(i * 3), i[0], 3'(i % 8));
      rtu_rsp_ack_i[1] = (i % 3 != 0);
      cycle();
    end
    idle(); rtu_rsp_ack_i[1] = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    idle();

    // T5: port 6 occupant, push+ack at count 2 on port 5, then flush+push on port 5
    push(6, 7'h40, 1'b1, 3'd6); cycle();
    push(5, 7'h01, 1'b0, 3'd1); cycle();
    push(5, 7'h02, 1'b0, 3'd2); cycle();
    push(5, 7'h03, 1'b0, 3'd3); rtu_rsp_ack_i[5] = 1'b1; cycle();
    chk("t5_count", 64'(q[5].size()), 64'd2);
    idle(); push(5, 7'h04, 1'b0, 3'd4); rtu_flush_i[5] = 1'b1; cycle();
    chk("t5_flushed", 64'(rtu_rsp_valid_o[5]), 64'd0);
    chk("t5_port6",   64'(rtu_rsp_valid_o[6]), 64'd1);
    idle(); rtu_rsp_ack_i[6] = 1'b1; cycle();
    idle();

    // T6: out-of-range port index
    push(7, 7'h55, 1'b1, 3'd3); cycle();
    chk("t6_err", 64'(err_bad_port_o), 64'd1);
    chk("t6_novalid", 64'(rtu_rsp_valid_o), 64'd0);
    idle(); cycle();
    chk("t6_err_clear", 64'(err_bad_port_o), 64'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rtu_valid_i   = ($urandom_range(0, 3) != 0);
      rtu_port_i    = 3'($urandom_range(0, 7));
      rtu_mask_i    = 7'($urandom);
      rtu_drop_i    = 1'($urandom);
      rtu_prio_i    = 3'($urandom);
      rtu_rsp_ack_i = 7'($urandom) & 7'($urandom);
      rtu_flush_i   = '0;
      if ($urandom_range(0, 15) == 0) rtu_flush_i[$urandom_range(0, N - 1)] = 1'b1;
      cycle();
    end
    idle(); rtu_rsp_ack_i = '1;
    for (int i = 0; i < 5; i++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
